// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared mux-select codes, FSM states and defaults for the PC sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_FLUSH = 2'd2} state_t;
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0;
  localparam int CNT_W = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-stage control, PC mux and instruction-memory handshake bundle
interface pc_sequencer_if #(parameter int WIDTH = 16);
  logic stall;
  logic br_taken;
  logic jmp;
  logic imem_ack;
  logic [WIDTH-1:0] pc_mux_in;
  logic [1:0] pc_sel;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc;
  logic imem_req;
  logic if_valid;
  logic flush;
  modport master (
    input stall, br_taken, jmp, imem_ack, pc_mux_in,
    output pc_sel, pc_inc, pc, imem_req, if_valid, flush
  );
  modport slave (
    output stall, br_taken, jmp, imem_ack, pc_mux_in,
    input pc_sel, pc_inc, pc, imem_req, if_valid, flush
  );
endinterface

// File: rtl/pc_sequencer_flush_ctr.sv
// pc_flush_ctr: loadable down-counter that saturates at zero and flags it
module pc_flush_ctr
  import pc_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic [CNT_W-1:0] load_val,
  output logic zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, drives the external PC mux select and the imem handshake,
// and inserts flush bubbles after every branch/jump redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.master bus
);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  state_t state, state_nxt;
  logic redirect, take, accept, zero;
  assign redirect = bus.jmp | bus.br_taken;
  assign take = redirect & (state != ST_BOOT);
  // an ack that coincides with a redirect fetched the wrong path and is dropped
  assign accept = bus.imem_req & bus.imem_ack & ~redirect;
  pc_flush_ctr u_flush_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .load(take),
    .dec(state == ST_FLUSH),
    .load_val(FLUSH_LOAD),
    .zero(zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == ST_BOOT ? ST_FETCH :
                take ? ST_FLUSH :
                (state == ST_FLUSH && !zero) ? ST_FLUSH : ST_FETCH;
  end
  always_comb begin
    bus.pc_sel = bus.jmp ? PC_SEL_JMP : bus.br_taken ? PC_SEL_BR : PC_SEL_SEQ;
    bus.imem_req = (state == ST_FETCH) & ~bus.stall;
    bus.flush = (state == ST_FLUSH);
  end
  assign bus.pc_inc = bus.pc + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pc <= RESET_PC;
      bus.if_valid <= 1'b0;
    end else begin
      if (take | accept) bus.pc <= bus.pc_mux_in;
      bus.if_valid <= accept;
    end
  end
endmodule
